// File: rtl/ps2_mouse_cmd_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the clock, issues
// request-to-send, shifts an 11-bit frame on device clock falls, checks ACK.
module ps2_mouse_cmd_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 100,
  parameter int unsigned FILTER         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Start,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  input  logic       Ps2_Clk_In,
  output logic       Ps2_Clk_Oe,
  input  logic       Ps2_Data_In,
  output logic       Ps2_Data_Oe
);
  localparam int CW = 20;
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST     = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(FILTER - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_REL, S_FAIL
  } state_t;

  // bit 0 = clock pad, bit 1 = data pad
  logic [1:0]    meta_reg, sync_reg;
  logic          clk_s, data_s;
  logic          filt_reg, fall_reg;
  logic [CW-1:0] filt_cnt_reg;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic [9:0]    frame_reg, frame_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;
  logic          clk_oe_reg, clk_oe_next;
  logic          data_oe_reg, data_oe_next;
  logic          timeout;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      meta_reg <= 2'b11;
      sync_reg <= 2'b11;
    end else begin
      meta_reg <= {Ps2_Data_In, Ps2_Clk_In};
      sync_reg <= meta_reg;
    end
  end

  assign clk_s  = sync_reg[0];
  assign data_s = sync_reg[1];

  // Level only moves after FILTER consecutive samples that disagree with it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_s == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILTER_LAST) begin
        filt_reg     <= clk_s;
        filt_cnt_reg <= '0;
        fall_reg     <= ~clk_s;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      frame_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      frame_reg   <= frame_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    idx_next     = idx_reg;
    frame_next   = frame_reg;
    data_oe_next = data_oe_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;
    timeout      = (cnt_reg == TIMEOUT_LAST);
    case (state_reg)
      S_IDLE: begin
        cnt_next     = '0;
        data_oe_next = 1'b0;
        if (Tx_Start) begin
          state_next = S_INHIBIT;
          frame_next = {1'b1, ~^Tx_Data, Tx_Data};
        end
      end
      S_INHIBIT: begin
        if (cnt_reg == INHIBIT_LAST) begin
          state_next   = S_RTS;
          cnt_next     = '0;
          data_oe_next = 1'b1;
        end
      end
      S_RTS: begin
        if (cnt_reg == RTS_LAST) begin
          state_next = S_SEND;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      S_SEND: begin
        if (timeout) begin
          state_next = S_FAIL;
        end else if (fall_reg) begin
          data_oe_next = ~frame_reg[idx_reg];
          idx_next     = idx_reg + 4'd1;
          if (idx_reg == 4'd9) state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (timeout)       state_next = S_FAIL;
        else if (fall_reg) state_next = data_s ? S_FAIL : S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (timeout) begin
          state_next = S_FAIL;
        end else if (filt_reg && data_s) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      S_FAIL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_FAIL) begin
      error_next   = 1'b1;
      data_oe_next = 1'b0;
    end
    busy_next   = (state_next != S_IDLE) && (state_next != S_FAIL);
    clk_oe_next = (state_next == S_INHIBIT) || (state_next == S_RTS);
  end

  assign Busy        = busy_reg;
  assign Done        = done_reg;
  assign Error       = error_reg;
  assign Ps2_Clk_Oe  = clk_oe_reg;
  assign Ps2_Data_Oe = data_oe_reg;
endmodule

// File: tb/tb_ps2_mouse_cmd_tx.sv
// Bench for ps2_mouse_cmd_tx: device model on open-drain pads, frame-bit
// scoreboard, vector table plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_mouse_cmd_tx;
  localparam int INH  = 200;
  localparam int RTS  = 20;
  localparam int FILT = 8;
  localparam int TMO  = 3000;
  localparam int HALF = 50;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       ack;
    logic       glitch;
    logic       poke;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_Start = 1'b0;
  logic       Busy, Done, Error, Ps2_Clk_Oe, Ps2_Data_Oe;
  logic       Ps2_Clk_In, Ps2_Data_In;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign Ps2_Clk_In  = ~(Ps2_Clk_Oe | dev_clk_low);
  assign Ps2_Data_In = ~(Ps2_Data_Oe | dev_data_low);

  always #5 Clk = ~Clk;

  ps2_mouse_cmd_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .FILTER        (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Tx_Data    (Tx_Data),
    .Tx_Start   (Tx_Start),
    .Busy       (Busy),
    .Done       (Done),
    .Error      (Error),
    .Ps2_Clk_In (Ps2_Clk_In),
    .Ps2_Clk_Oe (Ps2_Clk_Oe),
    .Ps2_Data_In(Ps2_Data_In),
    .Ps2_Data_Oe(Ps2_Data_Oe)
  );

  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cycles = 0;
  int   err_cycles = 0;
  int   both_cycles = 0;
  logic exp_q[$];
  vec_t vecs[5];

  always @(negedge Clk) begin
    if (Done) done_cycles++;
    if (Error) err_cycles++;
    if (Done && Error) both_cycles++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  task automatic capture(input string name);
    logic e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check(name, Ps2_Data_In, e);
    end
  endtask

  // Starts a frame and measures the inhibit / request-to-send windows;
  // returns at the first negedge with the clock pad released (SEND entry).
  task automatic launch(input logic [7:0] d, input logic poke);
    int g;
    int oe_cnt;
    int inh_cnt;
    g = 0;
    while (Busy && g < 500) begin
      @(negedge Clk);
      g++;
    end
    Tx_Data  = d;
    Tx_Start = 1'b1;
    @(negedge Clk);
    Tx_Start = 1'b0;
    Tx_Data  = ~d;
    check("busy_launch", Busy, 1);
    oe_cnt  = 0;
    inh_cnt = 0;
    while (Ps2_Clk_Oe && oe_cnt < INH + RTS + 50) begin
      oe_cnt++;
      if (!Ps2_Data_Oe) inh_cnt++;
      if (poke && oe_cnt == 3) Tx_Start = 1'b1;
      if (oe_cnt == 4) Tx_Start = 1'b0;
      @(negedge Clk);
    end
    check("clk_oe_len", oe_cnt, INH + RTS);
    check("inhibit_len", inh_cnt, INH);
    check("busy_send", Busy, 1);
  endtask

  // Device clocking: bits are captured on each rising edge of the pad clock,
  // the first one being the release at the end of request-to-send.
  task automatic clock_bits(input int nfalls, input logic ack,
                            input logic glitch, input logic stop_low);
    capture("bit_start");
    for (int i = 0; i < nfalls; i++) begin
      repeat (HALF) @(negedge Clk);
      dev_clk_low = 1'b1;
      if (i == 10 && ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge Clk);
      if (stop_low && i == nfalls - 1) return;
      dev_clk_low = 1'b0;
      if (i < 10) capture($sformatf("bit_%0d", i + 1));
      if (glitch && (i == 3 || i == 7)) begin
        repeat (20) @(negedge Clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge Clk);
        dev_clk_low = 1'b0;
      end
    end
    repeat (5) @(negedge Clk);
    dev_data_low = 1'b0;
  endtask

  task automatic run_frame(input int n, input vec_t v);
    int d0;
    int e0;
    int g;
    d0 = done_cycles;
    e0 = err_cycles;
    push_frame(v.data, v.parity);
    launch(v.data, v.poke);
    clock_bits(11, v.ack, v.glitch, 1'b0);
    g = 0;
    while (Busy && g < 500) begin
      @(negedge Clk);
      g++;
    end
    repeat (3) @(negedge Clk);
    check("done_pulses", done_cycles - d0, int'(v.exp_done));
    check("error_pulses", err_cycles - e0, int'(v.exp_err));
    check("busy_end", Busy, 0);
    check("clk_oe_end", Ps2_Clk_Oe, 0);
    check("data_oe_end", Ps2_Data_Oe, 0);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    $display("frame %0d: data=%02h ack=%0d glitch=%0d poke=%0d done=%0d error=%0d",
             n, v.data, v.ack, v.glitch, v.poke, done_cycles - d0, err_cycles - e0);
  endtask

  initial begin
    int d0;
    int e0;
    int cnt;
    vec_t v;

    vecs[0] = '{data: 8'hF4, parity: 1'b0, ack: 1'b1, glitch: 1'b0, poke: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'hFF, parity: 1'b1, ack: 1'b1, glitch: 1'b0, poke: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 8'h00, parity: 1'b1, ack: 1'b1, glitch: 1'b1, poke: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 8'hA5, parity: 1'b1, ack: 1'b1, glitch: 1'b1, poke: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'hF4, parity: 1'b0, ack: 1'b0, glitch: 1'b0, poke: 1'b0, exp_done: 1'b0, exp_err: 1'b1};

    repeat (3) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_clk_oe", Ps2_Clk_Oe, 0);
    check("rst_data_oe", Ps2_Data_Oe, 0);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);

    for (int i = 0; i < 5; i++) run_frame(i, vecs[i]);

    // Device never clocks: Error exactly TMO cycles after SEND entry.
    d0 = done_cycles;
    e0 = err_cycles;
    launch(8'hF4, 1'b0);
    cnt = 0;
    while (!Error && cnt < TMO + 100) begin
      @(negedge Clk);
      cnt++;
    end
    check("timeout_cycles", cnt, TMO);
    check("timeout_busy", Busy, 0);
    check("timeout_clk_oe", Ps2_Clk_Oe, 0);
    check("timeout_data_oe", Ps2_Data_Oe, 0);
    repeat (3) @(negedge Clk);
    check("timeout_err_pulses", err_cycles - e0, 1);
    check("timeout_done_pulses", done_cycles - d0, 0);
    $display("timeout: data=f4 cycles=%0d error=%0d", cnt, err_cycles - e0);

    // Reset while bit 4 (a zero) of 0xE8 is on the wire.
    push_frame(8'hE8, 1'b1);
    launch(8'hE8, 1'b0);
    clock_bits(5, 1'b0, 1'b0, 1'b1);
    check("bit4_data_oe", Ps2_Data_Oe, 1);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("arst_clk_oe", Ps2_Clk_Oe, 0);
    check("arst_data_oe", Ps2_Data_Oe, 0);
    check("arst_busy", Busy, 0);
    @(negedge Clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    $display("reset: data=e8 aborted at bit 4 busy=%0d", Busy);
    repeat (20) @(negedge Clk);
    v = vecs[0];
    run_frame(5, v);

    check("done_error_overlap", both_cycles, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ps2_mouse_cmd_tx.md
# ps2_mouse_cmd_tx

Host-to-device PS/2 command transmitter for the mouse controller. It sends one command byte to the mouse, for example 0xF4 "enable data reporting" or 0xFF "reset". It does this by inhibiting the PS/2 clock, issuing request-to-send, and shifting the 11-bit frame out on edges of the device-generated clock. It then checks the device acknowledge bit and reports Done or Error to the controller FSM. The block sits beside the mouse receive path and drives the open-drain PS/2 pads through output-enable lines.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000 — Clk cycles the PS/2 clock is held low before request-to-send (100 µs at 50 MHz).
- RTS_CYCLES, 100 — Clk cycles both lines are held low before the clock is released.
- FILTER, 8 — consecutive equal samples required to accept a new PS/2 clock level.
- TIMEOUT_CYCLES, 750000 — maximum Clk cycles from entering SEND until the ACK edge (15 ms).

Ports:
- Clk  in  1  system clock. One clock domain; all logic on posedge Clk.
- Rst  in  1  asynchronous, active-high reset.
- Tx_Data  in  8  command byte. Sampled on an accepted Tx_Start.
- Tx_Start  in  1  one-cycle request. Accepted only when Busy=0.
- Busy  out  1  high from the cycle after acceptance until Done/Error.
- Done  out  1  one-cycle pulse: frame sent and ACK received.
- Error  out  1  one-cycle pulse: missing ACK or timeout.
- Ps2_Clk_In  in  1  PS/2 clock pad level (asynchronous).
- Ps2_Clk_Oe  out  1  1 = drive PS/2 clock pad low; 0 = release.
- Ps2_Data_In  in  1  PS/2 data pad level (asynchronous).
- Ps2_Data_Oe  out  1  1 = drive PS/2 data pad low; 0 = release.

## Operation
- **Input conditioning**
  - Ps2_Clk_In and Ps2_Data_In each pass through a 2-FF synchronizer. Reset value is 1.
  - The synchronized clock feeds the filter. The filtered clock (reset value 1) changes only after FILTER consecutive samples of the new level.
  - fall_edge is a one-cycle pulse on a filtered 1→0 transition.
- **Frame**
  - Bits in order: start 0, data[0]..data[7] (LSB first), odd parity (~^Tx_Data), stop 1.
  - Data_Oe = ~bit. The stop bit is sent by releasing the data line.
- **States**
  - **IDLE**: both Oe=0, Busy=0. On Tx_Start, latch the data and parity, clear the counter, and go to INHIBIT.
  - **INHIBIT**: Clk_Oe=1, Data_Oe=0 for INHIBIT_CYCLES cycles, then go to RTS.
  - **RTS**: Clk_Oe=1, Data_Oe=1 (start bit) for RTS_CYCLES cycles, then go to SEND. Clear the timeout counter and set bit index = 0.
  - **SEND**: Clk_Oe=0.
    - Each fall_edge presents the next bit: index 0..7 data, 8 parity, 9 stop.
    - After the 10th fall_edge (stop presented, Data_Oe=0), go to ACK.
  - **ACK**: on the next fall_edge, sample the synchronized data line.
    - 0 → WAIT_REL.
    - 1 → FAIL.
  - **WAIT_REL**: wait until the filtered clock = 1 and the synchronized data = 1, then pulse Done and return to IDLE.
  - **FAIL**: pulse Error, both Oe=0, return to IDLE.
- **Timeout**
  - The counter runs in SEND, ACK and WAIT_REL.
  - When it reaches TIMEOUT_CYCLES, go to FAIL. This has priority over a fall_edge in the same cycle.
  - Counter width is 20 bits; parameters must not exceed 2^20−1.
- **Other rules**
  - Tx_Start while Busy=1 is ignored; no queueing.
  - Done and Error are never high together.

## Timing
- **Reset**
  - All outputs are registered. Reset values: Busy=0, Done=0, Error=0, Ps2_Clk_Oe=0, Ps2_Data_Oe=0. State = IDLE.
  - Reset during any state releases both pads immediately (asynchronously). After reset, the next Tx_Start starts a fresh frame.
- **Launch**
  - Tx_Start at cycle 0 → Busy=1 and Clk_Oe=1 at cycle 1.
  - Data_Oe=1 at cycle 1+INHIBIT_CYCLES.
  - Clk_Oe=0 at cycle 1+INHIBIT_CYCLES+RTS_CYCLES.
- **Bit update latency**
  - Data_Oe updates 1 cycle after fall_edge.
  - fall_edge occurs 2+FILTER cycles after the pad falls.
  - Total is about 11 cycles, far inside the device's ≥30 µs clock-low time.
- **Completion**
  - Done/Error pulse in the same cycle Busy returns to 0.
  - Tx_Start is accepted again from the following cycle.

## Test plan
- **Send 0xF4** with a device model clocking 40 µs/bit and acknowledging.
  - Captured bits on rising edges: 0, 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Done pulses once; Busy=0; Error stays 0.
- **Send 0xFF.**
  - Parity bit = 1; Ps2_Data_Oe=0 during all data bits; Done pulses.
- **Device leaves data high on the 11th falling edge.**
  - Error pulses for 1 cycle; Done=0; both Oe=0.
- **Device never clocks after RTS.**
  - Error pulses exactly TIMEOUT_CYCLES cycles after SEND entry.
- **Glitches and pre-start checks:**
  - Inject 3-cycle low glitches (< FILTER) on Ps2_Clk_In mid-frame → no bit advance; the frame still completes correctly.
  - Assert Tx_Start with Busy=1 → ignored.
  - Measure Clk_Oe low duration = INHIBIT_CYCLES+RTS_CYCLES.
- **Assert Rst during SEND at bit 4.**
  - Both Oe drop to 0 before the next Clk edge; Busy=0.
  - A following 0xF4 transfer completes with Done.
